// File: rtl/spi_pkg.sv
// Shared types and helpers for the multi-chip-select SPI master.
package spi_pkg;

    // Transaction FSM states
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SETUP       = 3'd1,
        ST_TRANSFER    = 3'd2,
        ST_WAIT_WORD   = 3'd3,
        ST_CS_HOLD     = 3'd4,
        ST_CS_INACTIVE = 3'd5
    } state_t;

    // Clock polarity of an SPI mode {CPOL,CPHA}
    function automatic logic cpol(input logic [1:0] mode);
        return mode[1];
    endfunction

    // Clock phase of an SPI mode {CPOL,CPHA}
    function automatic logic cpha(input logic [1:0] mode);
        return mode[0];
    endfunction

    // Width of a word counter able to hold 0..max_words
    function automatic int cw_f(input int max_words);
        return $clog2(max_words + 1);
    endfunction

    // Width of an index into n items, never below one bit
    function automatic int sw_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_master_multi_cs_if.sv
// Host command and SPI pin bundle for spi_master_multi_cs.
interface spi_master_multi_cs_if
    import spi_pkg::*;
#(
    parameter int NUM_CS           = 4,
    parameter int DATA_WIDTH       = 8,
    parameter int MAX_WORDS_PER_CS = 4
);
    localparam int CW = cw_f(MAX_WORDS_PER_CS);
    localparam int SW = sw_f(NUM_CS);

    logic [CW-1:0]         i_TX_Count;
    logic [SW-1:0]         i_CS_Sel;
    logic [1:0]            i_Mode;
    logic [DATA_WIDTH-1:0] i_TX_Word;
    logic                  i_TX_DV;
    logic                  o_TX_Ready;
    logic [CW-1:0]         o_RX_Count;
    logic                  o_RX_DV;
    logic [DATA_WIDTH-1:0] o_RX_Word;
    logic                  o_Err;
    logic                  o_Busy;
    logic                  o_SPI_Clk;
    logic                  i_SPI_MISO;
    logic                  o_SPI_MOSI;
    logic [NUM_CS-1:0]     o_SPI_CS_n;

    modport master (
        input  i_TX_Count, i_CS_Sel, i_Mode, i_TX_Word, i_TX_DV, i_SPI_MISO,
        output o_TX_Ready, o_RX_Count, o_RX_DV, o_RX_Word, o_Err, o_Busy,
        output o_SPI_Clk, o_SPI_MOSI, o_SPI_CS_n
    );

    modport slave (
        output i_TX_Count, i_CS_Sel, i_Mode, i_TX_Word, i_TX_DV, i_SPI_MISO,
        input  o_TX_Ready, o_RX_Count, o_RX_DV, o_RX_Word, o_Err, o_Busy,
        input  o_SPI_Clk, o_SPI_MOSI, o_SPI_CS_n
    );

endinterface

// File: rtl/spi_word_engine.sv
// One full-duplex DATA_WIDTH-bit SPI word, MSB first, for a latched mode.
// SCLK rests at the latched CPOL whenever no word is running.
module spi_word_engine
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH        = 8,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int RESET_MODE        = 0
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic                  i_Load,
    input  logic [1:0]            i_Mode,
    input  logic                  i_Start,
    input  logic [DATA_WIDTH-1:0] i_Word,
    input  logic                  i_MISO,
    output logic                  o_SCLK,
    output logic                  o_MOSI,
    output logic                  o_RX_DV,
    output logic [DATA_WIDTH-1:0] o_RX_Word,
    output logic                  o_Done
);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam int HW = $clog2(CLKS_PER_HALF_BIT);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [HW-1:0] LAST_HC  = HW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [1:0]    RST_MODE = RESET_MODE[1:0];

    logic                  run_q;
    logic [HW-1:0]         hc_q;
    logic [BW-1:0]         bit_q;
    logic                  trail_q;
    logic                  cpol_q;
    logic                  cpha_q;
    logic                  sclk_q;
    logic                  mosi_q;
    logic [DATA_WIDTH-1:0] tx_sr_q;
    logic [DATA_WIDTH-1:0] rx_sr_q;
    logic [DATA_WIDTH-1:0] rx_word_q;
    logic                  rx_dv_q;
    logic                  done_q;
    logic                  sample_edge;

    // CPHA=0 samples on the leading edge, CPHA=1 on the trailing edge
    assign sample_edge = (trail_q == cpha_q);

    // Half-bit timing, SCLK toggling, shift-out and sample-in
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            run_q     <= 1'b0;
            hc_q      <= '0;
            bit_q     <= '0;
            trail_q   <= 1'b0;
            cpol_q    <= cpol(RST_MODE);
            cpha_q    <= cpha(RST_MODE);
            sclk_q    <= cpol(RST_MODE);
            mosi_q    <= 1'b0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_word_q <= '0;
            rx_dv_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            rx_dv_q <= 1'b0;
            done_q  <= 1'b0;
            if (i_Load && !run_q) begin
                cpol_q <= cpol(i_Mode);
                cpha_q <= cpha(i_Mode);
                sclk_q <= cpol(i_Mode);
            end else if (i_Start && !run_q) begin
                run_q   <= 1'b1;
                hc_q    <= '0;
                bit_q   <= '0;
                trail_q <= 1'b0;
                if (!cpha_q) begin
                    mosi_q  <= i_Word[DATA_WIDTH-1];
                    tx_sr_q <= {i_Word[DATA_WIDTH-2:0], 1'b0};
                end else begin
                    tx_sr_q <= i_Word;
                end
            end else if (run_q) begin
                if (hc_q != LAST_HC) begin
                    hc_q <= hc_q + 1'b1;
                end else begin
                    hc_q   <= '0;
                    sclk_q <= ~sclk_q;
                    if (sample_edge) begin
                        rx_sr_q <= {rx_sr_q[DATA_WIDTH-2:0], i_MISO};
                        if (bit_q == LAST_BIT) begin
                            rx_word_q <= {rx_sr_q[DATA_WIDTH-2:0], i_MISO};
                            rx_dv_q   <= 1'b1;
                        end
                    end else begin
                        mosi_q  <= tx_sr_q[DATA_WIDTH-1];
                        tx_sr_q <= {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
                    end
                    if (trail_q) begin
                        trail_q <= 1'b0;
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == LAST_BIT) begin
                            run_q  <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end else begin
                        trail_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_SCLK    = sclk_q;
    assign o_MOSI    = mosi_q;
    assign o_RX_DV   = rx_dv_q;
    assign o_RX_Word = rx_word_q;
    assign o_Done    = done_q;

endmodule

// File: rtl/spi_master_multi_cs.sv
// SPI master with NUM_CS chip selects and multi-word bursts under one CS.
// Owns the transaction FSM, CS decode, word counting and the CS-high gap.
module spi_master_multi_cs
    import spi_pkg::*;
#(
    parameter int NUM_CS            = 4,
    parameter int DATA_WIDTH        = 8,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int MAX_WORDS_PER_CS  = 4,
    parameter int CS_INACTIVE_CLKS  = 1,
    parameter int RESET_MODE        = 0
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    spi_master_multi_cs_if.master bus
);
    localparam int CW = cw_f(MAX_WORDS_PER_CS);
    localparam int SW = sw_f(NUM_CS);
    localparam int HW = $clog2(CLKS_PER_HALF_BIT);
    localparam int IW = sw_f(CS_INACTIVE_CLKS);
    localparam logic [SW:0]   NCS     = (SW+1)'(NUM_CS);
    localparam logic [HW-1:0] LAST_HC = HW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [IW-1:0] LAST_IC = IW'(CS_INACTIVE_CLKS - 1);

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         idx_q;
    logic [SW-1:0]         sel_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic [NUM_CS-1:0]     cs_n_q;
    logic [CW-1:0]         rx_cnt_q;
    logic [HW-1:0]         tmr_q;
    logic [IW-1:0]         itmr_q;
    logic                  pend_q;
    logic                  ready_q;
    logic                  err_q;
    logic                  busy_q;

    logic                  req_bad;
    logic                  eng_load;
    logic                  eng_start;
    logic                  eng_done;
    logic                  eng_sclk;
    logic                  eng_mosi;
    logic                  eng_rx_dv;
    logic [DATA_WIDTH-1:0] eng_rx_word;

    // A request is rejected for an empty burst or a nonexistent chip select
    assign req_bad   = (bus.i_TX_Count == '0) || ({1'b0, bus.i_CS_Sel} >= NCS);
    assign eng_load  = (state_q == ST_IDLE) && bus.i_TX_DV && !req_bad;
    assign eng_start = (state_q == ST_SETUP) ||
                       ((state_q == ST_TRANSFER) && pend_q && (tmr_q == '0));

    spi_word_engine #(
        .DATA_WIDTH        (DATA_WIDTH),
        .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT),
        .RESET_MODE        (RESET_MODE)
    ) u_engine (
        .i_Clk     (i_Clk),
        .i_Rst_L   (i_Rst_L),
        .i_Load    (eng_load),
        .i_Mode    (bus.i_Mode),
        .i_Start   (eng_start),
        .i_Word    (word_q),
        .i_MISO    (bus.i_SPI_MISO),
        .o_SCLK    (eng_sclk),
        .o_MOSI    (eng_mosi),
        .o_RX_DV   (eng_rx_dv),
        .o_RX_Word (eng_rx_word),
        .o_Done    (eng_done)
    );

    // Transaction FSM with registered handshake and chip-select outputs
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            sel_q    <= '0;
            word_q   <= '0;
            cs_n_q   <= '1;
            rx_cnt_q <= '0;
            tmr_q    <= '0;
            itmr_q   <= '0;
            pend_q   <= 1'b0;
            ready_q  <= 1'b1;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_TX_DV) begin
                        if (req_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            cnt_q   <= bus.i_TX_Count;
                            sel_q   <= bus.i_CS_Sel;
                            word_q  <= bus.i_TX_Word;
                            idx_q   <= '0;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    cs_n_q   <= ~(NUM_CS'(1) << sel_q);
                    rx_cnt_q <= idx_q;
                    idx_q    <= idx_q + 1'b1;
                    state_q  <= ST_TRANSFER;
                end
                ST_TRANSFER: begin
                    if (pend_q) begin
                        if (tmr_q == '0) begin
                            pend_q   <= 1'b0;
                            rx_cnt_q <= idx_q;
                            idx_q    <= idx_q + 1'b1;
                        end else begin
                            tmr_q <= tmr_q - 1'b1;
                        end
                    end else if (eng_done) begin
                        if (idx_q == cnt_q) begin
                            tmr_q   <= LAST_HC;
                            state_q <= ST_CS_HOLD;
                        end else begin
                            ready_q <= 1'b1;
                            state_q <= ST_WAIT_WORD;
                        end
                    end
                end
                ST_WAIT_WORD: begin
                    if (bus.i_TX_DV) begin
                        word_q  <= bus.i_TX_Word;
                        ready_q <= 1'b0;
                        pend_q  <= 1'b1;
                        tmr_q   <= LAST_HC;
                        state_q <= ST_TRANSFER;
                    end
                end
                ST_CS_HOLD: begin
                    if (tmr_q == '0) begin
                        cs_n_q   <= '1;
                        rx_cnt_q <= '0;
                        itmr_q   <= LAST_IC;
                        state_q  <= ST_CS_INACTIVE;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                ST_CS_INACTIVE: begin
                    if (itmr_q == '0) begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        itmr_q <= itmr_q - 1'b1;
                    end
                end
                default: begin
                    cs_n_q  <= '1;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_TX_Ready = ready_q;
    assign bus.o_RX_Count = rx_cnt_q;
    assign bus.o_RX_DV    = eng_rx_dv;
    assign bus.o_RX_Word  = eng_rx_word;
    assign bus.o_Err      = err_q;
    assign bus.o_Busy     = busy_q;
    assign bus.o_SPI_Clk  = eng_sclk;
    assign bus.o_SPI_MOSI = eng_mosi;
    assign bus.o_SPI_CS_n = cs_n_q;

endmodule

// File: tb/tb_spi_master_multi_cs.sv
// Directed bench for spi_master_multi_cs with a MOSI->MISO loopback and an
// RX scoreboard; three chip selects and a five-cycle CS-high gap.
module tb_spi_master_multi_cs;
    localparam int NCS = 3;
    localparam int DW  = 8;

    typedef struct packed {
        logic [DW-1:0] word;
        logic [2:0]    idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   miso_inv = 1'b0;
    bit   mosi_chk_en = 1'b0;

    int   errors = 0;
    int   checks = 0;
    int   edges = 0;
    int   idle_toggles = 0;
    int   rx_dv_cnt = 0;
    int   cs_viol = 0;
    int   mosi_viol = 0;

    exp_t sb[$];

    logic           prev_sclk = 1'b0;
    logic           prev_mosi = 1'b0;
    logic [NCS-1:0] prev_cs = '1;

    spi_master_multi_cs_if #(.NUM_CS(NCS), .DATA_WIDTH(DW), .MAX_WORDS_PER_CS(4)) bus ();

    assign bus.i_SPI_MISO = bus.o_SPI_MOSI ^ miso_inv;

    spi_master_multi_cs #(
        .NUM_CS            (NCS),
        .DATA_WIDTH        (DW),
        .CLKS_PER_HALF_BIT (2),
        .MAX_WORDS_PER_CS  (4),
        .CS_INACTIVE_CLKS  (5),
        .RESET_MODE        (0)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop on every RX pulse, plus bus-wide invariants
    always @(negedge clk) begin
        exp_t e;
        if (bus.o_RX_DV === 1'b1) begin
            rx_dv_cnt++;
            if (sb.size() == 0) begin
                chk("rx_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("rx_word", bus.o_RX_Word, e.word);
                chk("rx_count", bus.o_RX_Count, e.idx);
            end
        end
        if (bus.o_SPI_Clk !== prev_sclk) begin
            edges++;
            if (&prev_cs && &bus.o_SPI_CS_n) idle_toggles++;
        end
        if ($countones(~bus.o_SPI_CS_n) > 1) cs_viol++;
        if (mosi_chk_en && !(&bus.o_SPI_CS_n) && !(&prev_cs) &&
            (bus.o_SPI_MOSI !== prev_mosi) &&
            !(prev_sclk === 1'b1 && bus.o_SPI_Clk === 1'b0))
            mosi_viol++;
        prev_sclk = bus.o_SPI_Clk;
        prev_mosi = bus.o_SPI_MOSI;
        prev_cs   = bus.o_SPI_CS_n;
    end

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.o_TX_Ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        chk(tag, bus.o_TX_Ready, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.o_Busy !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        chk(tag, bus.o_Busy, 0);
    endtask

    task automatic wait_cs(input logic [NCS-1:0] v, input string tag);
        int n = 0;
        while (bus.o_SPI_CS_n !== v && n < 2000) begin @(negedge clk); n++; end
        chk(tag, bus.o_SPI_CS_n, v);
    endtask

    // Pulse one request; returns at the negedge after the DUT sampled it
    task automatic send_req(input logic [2:0] cnt, input logic [1:0] sel, input logic [1:0] mode,
                            input logic [DW-1:0] w, input bit expect_ok);
        exp_t e;
        wait_ready("req_ready");
        bus.i_TX_Count = cnt;
        bus.i_CS_Sel   = sel;
        bus.i_Mode     = mode;
        bus.i_TX_Word  = w;
        bus.i_TX_DV    = 1'b1;
        if (expect_ok) begin
            e.word = miso_inv ? ~w : w;
            e.idx  = 3'd0;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.i_TX_DV = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] w, input logic [2:0] idx);
        exp_t e;
        wait_ready("word_ready");
        bus.i_TX_Word = w;
        bus.i_TX_DV   = 1'b1;
        e.word = miso_inv ? ~w : w;
        e.idx  = idx;
        sb.push_back(e);
        @(negedge clk);
        bus.i_TX_DV = 1'b0;
    endtask

    initial begin
        int e0;
        int rx0;
        int gap_bad;
        int low;
        int hi;
        bus.i_TX_Count = '0;
        bus.i_CS_Sel   = '0;
        bus.i_Mode     = '0;
        bus.i_TX_Word  = '0;
        bus.i_TX_DV    = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cs_n", bus.o_SPI_CS_n, 3'b111);
        chk("rst_sclk", bus.o_SPI_Clk, 0);
        chk("rst_mosi", bus.o_SPI_MOSI, 0);
        chk("rst_ready", bus.o_TX_Ready, 1);
        chk("rst_rx_dv", bus.o_RX_DV, 0);
        chk("rst_err", bus.o_Err, 0);
        chk("rst_busy", bus.o_Busy, 0);
        chk("rst_rx_word", bus.o_RX_Word, 0);
        chk("rst_rx_count", bus.o_RX_Count, 0);

        // 1: single word 0xA5, mode 0, sel 2
        edges = 0;
        send_req(3'd1, 2'd2, 2'd0, 8'hA5, 1'b1);
        chk("t1_setup_cs", bus.o_SPI_CS_n, 3'b111);
        @(negedge clk);
        chk("t1_cs_low", bus.o_SPI_CS_n, 3'b011);
        wait_idle("t1_idle");
        chk("t1_edges", edges, 16);
        chk("t1_rx_cnt", rx_dv_cnt, 1);
        chk("t1_cs_high", bus.o_SPI_CS_n, 3'b111);

        // 2: three-word burst on sel 0, 20-cycle gap before the second word
        send_req(3'd3, 2'd0, 2'd0, 8'h12, 1'b1);
        wait_ready("t2_wait_word");
        chk("t2_cs_held", bus.o_SPI_CS_n, 3'b110);
        chk("t2_first_rx", rx_dv_cnt, 2);
        gap_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.o_SPI_CS_n !== 3'b110 || bus.o_SPI_Clk !== 1'b0) gap_bad++;
        end
        chk("t2_gap_idle", gap_bad, 0);
        send_word(8'h34, 3'd1);
        send_word(8'h56, 3'd2);
        wait_idle("t2_idle");
        chk("t2_rx_cnt", rx_dv_cnt, 4);
        chk("t2_rx_count_clr", bus.o_RX_Count, 0);

        // 3: mode 0 then mode 3 on sel 1
        mosi_chk_en = 1'b1;
        send_req(3'd1, 2'd1, 2'd0, 8'h3C, 1'b1);
        wait_idle("t3a_idle");
        idle_toggles = 0;
        send_req(3'd1, 2'd1, 2'd3, 8'hC3, 1'b1);
        chk("t3_setup_sclk", bus.o_SPI_Clk, 1);
        chk("t3_setup_cs", bus.o_SPI_CS_n, 3'b111);
        @(negedge clk);
        chk("t3_cs_low", bus.o_SPI_CS_n, 3'b101);
        wait_idle("t3b_idle");
        mosi_chk_en = 1'b0;
        chk("t3_idle_toggles", idle_toggles, 1);
        chk("t3_mosi_on_fall", mosi_viol, 0);
        chk("t3_sclk_idle_hi", bus.o_SPI_Clk, 1);

        // 4: rejected requests (bad select, zero count)
        e0 = edges;
        send_req(3'd1, 2'd3, 2'd0, 8'hFF, 1'b0);
        chk("t4_err1", bus.o_Err, 1);
        chk("t4_ready1", bus.o_TX_Ready, 1);
        send_req(3'd0, 2'd0, 2'd0, 8'hFF, 1'b0);
        chk("t4_err2", bus.o_Err, 1);
        @(negedge clk);
        chk("t4_err_clear", bus.o_Err, 0);
        chk("t4_cs", bus.o_SPI_CS_n, 3'b111);
        chk("t4_no_edges", edges, e0);
        chk("t4_ready", bus.o_TX_Ready, 1);
        chk("t4_busy", bus.o_Busy, 0);

        // 5: reset after three bits of a mode 2 transfer
        rx0 = rx_dv_cnt;
        e0  = edges;
        send_req(3'd1, 2'd0, 2'd2, 8'h96, 1'b0);
        low = 0;
        while (edges < e0 + 6 && low < 2000) begin @(negedge clk); low++; end
        chk("t5_reach_bit3", (edges >= e0 + 6), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_cs_release", bus.o_SPI_CS_n, 3'b111);
        chk("t5_sclk_rst", bus.o_SPI_Clk, 0);
        chk("t5_busy_rst", bus.o_Busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_no_rx", rx_dv_cnt, rx0);
        miso_inv = 1'b1;
        send_req(3'd1, 2'd0, 2'd1, 8'h5A, 1'b1);
        wait_idle("t5_idle");
        miso_inv = 1'b0;
        chk("t5_rx_after", rx_dv_cnt, rx0 + 1);

        // 6: back-to-back transactions across the CS-high gap
        rx0 = rx_dv_cnt;
        send_req(3'd1, 2'd1, 2'd0, 8'h81, 1'b1);
        @(negedge clk);
        chk("t6_cs_low", bus.o_SPI_CS_n, 3'b101);
        wait_cs(3'b111, "t6_cs_rise");
        chk("t6_gap_ready", bus.o_TX_Ready, 0);
        bus.i_TX_Count = 3'd1;
        bus.i_CS_Sel   = 2'd0;
        bus.i_TX_Word  = 8'hEE;
        bus.i_TX_DV    = 1'b1;
        @(negedge clk);
        bus.i_TX_DV = 1'b0;
        chk("t6_gap_dv_err", bus.o_Err, 0);
        low = 1;
        while (bus.o_TX_Ready !== 1'b1 && low < 100) begin low++; @(negedge clk); end
        chk("t6_ready_low_cycles", low, 5);
        hi = low;
        send_req(3'd1, 2'd2, 2'd0, 8'h7E, 1'b1);
        hi++;
        while (bus.o_SPI_CS_n === 3'b111 && hi < 100) begin hi++; @(negedge clk); end
        chk("t6_cs_high_ge5", (hi >= 5), 1);
        chk("t6_cs_sel2", bus.o_SPI_CS_n, 3'b011);
        wait_idle("t6_idle");
        chk("t6_rx_cnt", rx_dv_cnt, rx0 + 2);

        // Global invariants
        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("cs_one_hot", cs_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
